// File: rtl/ifetch_queue_if.sv
// Bundle of fetch-side signals between the prefetch queue, instruction memory,
// the ID-stage redirect source and the IF/ID register.
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic [31:0]              imem_addr;
  logic [31:0]              imem_rdata;
  logic                     deq_ready;
  logic                     deq_valid;
  logic [31:0]              deq_instr;
  logic [31:0]              deq_pcplus4;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    input  redirect, redirect_pc, imem_rdata, deq_ready,
    output imem_addr, deq_valid, deq_instr, deq_pcplus4, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, deq_ready,
    input  imem_addr, deq_valid, deq_instr, deq_pcplus4, count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, fetches whenever there is room,
// and buffers {instr, PC+4} pairs for IF/ID; an ID-stage redirect flushes it.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR1_C  = AW'(1);

  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc4_mem_r   [DEPTH];
  logic [31:0]   fpc_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;

  logic          full_s;
  logic          deq_s;
  logic          enq_s;
  logic [31:0]   fpc_plus4_s;

  // Handshake decode; a full queue may still accept when its head is leaving.
  always_comb begin
    full_s      = (count_r == DEPTH_C);
    deq_s       = (count_r != '0) & bus.deq_ready;
    enq_s       = ~bus.redirect & (~full_s | deq_s);
    fpc_plus4_s = fpc_r + 32'd4;
  end

  // Fetch PC, pointers and occupancy; redirect outranks enqueue and dequeue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_r    <= RESET_PC;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (bus.redirect) begin
      fpc_r    <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        fpc_r    <= fpc_plus4_s;
        wr_ptr_r <= wr_ptr_r + PTR1_C;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PTR1_C;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observable through count, so no reset.
  always_ff @(posedge clk) begin
    if (rst && enq_s) begin
      instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
      pc4_mem_r[wr_ptr_r]   <= fpc_plus4_s;
    end
  end

  assign bus.imem_addr = fpc_r;
  assign bus.count     = count_r;

  // Head presentation, zeroed while empty.
  always_comb begin
    if (count_r != '0) begin
      bus.deq_valid   = 1'b1;
      bus.deq_instr   = instr_mem_r[rd_ptr_r];
      bus.deq_pcplus4 = pc4_mem_r[rd_ptr_r];
    end else begin
      bus.deq_valid   = 1'b0;
      bus.deq_instr   = 32'h0000_0000;
      bus.deq_pcplus4 = 32'h0000_0000;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (DEPTH=4); imem word i holds
// 32'h1000_0000 + i.
module tb_ifetch_queue;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ifetch_queue_if #(.DEPTH(4)) bus ();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] cnt);
    check({tag, ".valid"}, {31'b0, bus.deq_valid}, 32'd1);
    check({tag, ".instr"}, bus.deq_instr, 32'h1000_0000 + {2'b00, pc[31:2]});
    check({tag, ".pc4"},   bus.deq_pcplus4, pc + 32'd4);
    check({tag, ".count"}, {29'b0, bus.count}, cnt);
  endtask

  task automatic check_empty(input string tag, input logic [31:0] addr);
    check({tag, ".valid"}, {31'b0, bus.deq_valid}, 32'd0);
    check({tag, ".instr"}, bus.deq_instr, 32'd0);
    check({tag, ".pc4"},   bus.deq_pcplus4, 32'd0);
    check({tag, ".count"}, {29'b0, bus.count}, 32'd0);
    check({tag, ".addr"},  bus.imem_addr, addr);
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.deq_ready   = 1'b1;
    tick();
    tick();
    check_empty("reset", 32'd0);

    // Free run: one entry per cycle, count stays 1.
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_head($sformatf("run%0d", k), 32'(4 * (k - 1)), 32'd1);
      check($sformatf("run%0d.addr", k), bus.imem_addr, 32'(4 * k));
    end

    // Redirect to 0, then stall fill for 8 cycles.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'd0;
    tick();
    check_empty("redir0", 32'd0);
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_head($sformatf("fill%0d", k), 32'd0, (k < 4) ? 32'(k) : 32'd4);
      check($sformatf("fill%0d.addr", k), bus.imem_addr, (k < 4) ? 32'(4 * k) : 32'd16);
    end

    // Full with deq_ready=1: head advances, tail PC16 enters, count stays 4.
    bus.deq_ready = 1'b1;
    tick();
    check_head("fulldeq", 32'd4, 32'd4);
    check("fulldeq.addr", bus.imem_addr, 32'd20);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check_head($sformatf("drain%0d", k), 32'(4 * k), 32'd4);
    end

    // Redirect while full and ready: queue emptied, nothing enqueued.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick();
    check_empty("redirfull", 32'h0000_0100);
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_head($sformatf("refill%0d", k), 32'h0000_0100, 32'(k));
    end

    // Redirect to unaligned 0x43 with count=3.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    tick();
    check_empty("redir43", 32'h0000_0040);
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b1;
    tick();
    check_head("tgt40", 32'h0000_0040, 32'd1);

    // Address wrap, then 12 entries through the ring.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    check_empty("redirwrap", 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    tick();
    check_head("wraphead", 32'hFFFF_FFFC, 32'd1);
    check("wrap.addr", bus.imem_addr, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_head($sformatf("ring%0d", k), 32'(4 * (k - 1)), 32'd1);
    end

    // Reset mid-stream overrides a simultaneous redirect.
    rst             = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    check_empty("midrst", 32'd0);
    rst          = 1'b1;
    bus.redirect = 1'b0;
    tick();
    check_head("postrst", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of the pipelined MIPS CPU. Owns the fetch PC, reads the combinational instruction memory every cycle it has room, and buffers up to DEPTH {instruction, PC+4} pairs. IF/ID drains the queue with a valid/ready handshake, so an IF/ID stall no longer freezes fetch. A taken branch, jump or jr in ID redirects fetch and discards everything queued.

## Interface
- DEPTH, default 4: queue entries; power of two, 2..16.
- RESET_PC, default 32'h0000_0000: fetch address after reset; word-aligned.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- redirect  in  1  ID-stage control-transfer taken (PCSrc != 0).
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_addr  out  32  address to instruction memory; equals the fetch PC register.
- imem_rdata  in  32  instruction at imem_addr, same cycle (combinational memory).
- deq_ready  in  1  IF/ID accepts this cycle (not stalled).
- deq_valid  out  1  head entry valid.
- deq_instr  out  32  head instruction; 32'h0 when empty.
- deq_pcplus4  out  32  head PC+4; 32'h0 when empty.
- count  out  log2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- State: fpc (32-bit fetch PC), circular buffer of DEPTH entries {instr, pcplus4}, rd_ptr and wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count.
- imem_addr = fpc.
- deq = deq_valid & deq_ready.
- enq = !redirect & (count < DEPTH | deq). Same-cycle enqueue into a full queue is allowed when the head is leaving.
- On enq: write {imem_rdata, fpc+4} at wr_ptr. Advance wr_ptr. Set fpc <= fpc+4. fpc+4 wraps modulo 2^32.
- On deq (no redirect): advance rd_ptr.
- count_next = count + enq - deq. Simultaneous enq and deq leave count unchanged.
- Redirect has priority over everything:
  - rd_ptr, wr_ptr and count all become 0.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - No enqueue and no dequeue take effect that cycle. The head presented with deq_valid=1 in the redirect cycle is the delay-slot-free successor and is discarded.
- deq_valid = (count != 0). Head fields come from the entry at rd_ptr. They are forced to 0 when count == 0.
- No combinational path from imem_rdata to deq_*: an instruction always spends at least one cycle in the queue.
- deq_ready is not required to be stable; deq_valid does not depend on deq_ready.
- Full with deq_ready=0: fpc holds and imem_addr is stable until space frees.

## Timing
- Reset (rst=0 at an edge): fpc=RESET_PC, pointers=0, count=0, deq_valid=0, deq_instr=0, deq_pcplus4=0. rst=0 mid-operation discards all entries and overrides redirect.
- Fetch-to-head latency: 1 cycle. An instruction enqueued at edge k is at the head after edge k if the queue was empty.
- Redirect latency: redirect sampled at edge n.
  - After edge n: imem_addr = target, deq_valid=0.
  - After edge n+1: target instruction at the head, deq_valid=1.
- Steady state with deq_ready=1: one instruction per cycle, count holds at 1.
- Fill with deq_ready=0: count rises 1 per cycle and saturates at DEPTH. fpc stops advancing after DEPTH fetches.

## Test plan
- Reset then free-run, deq_ready=1, imem word i = 32'h1000_0000+i: first deq_valid one cycle after reset release with instr 32'h1000_0000, pcplus4 4. Then one entry per cycle with pcplus4 = 8, 12, …; count stays 1.
- Stall fill, DEPTH=4, deq_ready=0 for 8 cycles: count reaches 4 and holds; imem_addr freezes at 16. Release: entries for PC 0, 4, 8, 12, 16… in order, no loss or duplicate.
- Full with simultaneous deq_ready=1 for one cycle: count stays 4; head advances from PC 0 to PC 4; new tail is PC 16.
- Redirect to 32'h0000_0043 with count=3: next cycle count=0, deq_valid=0, imem_addr=32'h40. The following cycle the head holds the instr at 0x40 with pcplus4 32'h44.
- Redirect asserted while deq_ready=1 and full: the head is not consumed, the queue is emptied, and nothing is enqueued that cycle.
- Wrap: redirect to 32'hFFFF_FFFC, free-run: pcplus4 0, then the next fetch address is 0. Pointer wrap over 3×DEPTH entries preserves order.
- rst=0 asserted mid-stream together with redirect=1: after the edge all outputs are at reset values and imem_addr=RESET_PC.
